// File: rtl/store_align_buffer_pkg.sv
// Shared size codes, byte-enable constants and the queued store entry layout
// for the MEM-stage store alignment buffer.
package store_align_buffer_pkg;

  localparam logic [1:0] st_byte = 2'b00;
  localparam logic [1:0] st_half = 2'b01;
  localparam logic [1:0] st_word = 2'b10;
  localparam logic [1:0] st_none = 2'b11;

  localparam logic [3:0] be_none = 4'b0000;
  localparam logic [3:0] be_word = 4'b1111;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  // Half stores need an even address, word stores a word-aligned one.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] low);
    case (size)
      st_half: return low[0];
      st_word: return low != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_align_buffer_if.sv
// Pipeline-side store request, memory-side drain handshake and load hazard probe.
// Drain handshake: the head is transferred on any clock edge where mem_req and
// mem_ack are both 1; while mem_req=1 and mem_ack=0 all mem_* signals hold.
interface store_align_buffer_if #(parameter int DEPTH = 4);

  logic                      st_valid;
  logic [1:0]                st_size;
  logic [31:0]               st_addr;
  logic [31:0]               st_data;
  logic                      st_ready;
  logic                      st_exc;
  logic                      mem_req;
  logic [31:0]               mem_addr;
  logic [31:0]               mem_wdata;
  logic [3:0]                mem_be;
  logic                      mem_ack;
  logic [31:0]               ld_addr;
  logic                      ld_hit;
  logic                      buf_empty;
  logic [$clog2(DEPTH):0]    occupancy;

  modport master (
    output st_valid, st_size, st_addr, st_data, mem_ack, ld_addr,
    input  st_ready, st_exc, mem_req, mem_addr, mem_wdata, mem_be, ld_hit,
           buf_empty, occupancy
  );

  modport slave (
    input  st_valid, st_size, st_addr, st_data, mem_ack, ld_addr,
    output st_ready, st_exc, mem_req, mem_addr, mem_wdata, mem_be, ld_hit,
           buf_empty, occupancy
  );

endinterface

// File: rtl/store_align_buffer_fifo.sv
// In-order store queue; exposes every slot address plus a live mask so the
// top level can compare pending words against the load in MEM.
module store_fifo
  import store_align_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [29:0]      entry_addr [DEPTH],
  output logic [DEPTH-1:0] entry_valid
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] offset;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW + 1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push & !do_pop)      count <= count + (AW + 1)'(1);
      else if (!do_push & do_pop) count <= count - (AW + 1)'(1);
    end
  end

  // Payload needs no reset: a slot is only visible through entry_valid/head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    offset      = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i]  = mem[i].addr;
      offset         = AW'(i) - rd_ptr;
      entry_valid[i] = {1'b0, offset} < count;
    end
  end

endmodule

// File: rtl/store_align_buffer.sv
// MEM-stage store path: alignment check, byte enables, lane replication and
// an in-order write queue draining to memory, with a load-hit hazard flag.
module store_align_buffer
  import store_align_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  store_align_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic             mis;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  entry_t           new_entry;
  entry_t           head;
  logic [29:0]      entry_addr [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] match;
  logic             unused_ld_low;

  assign mis        = misaligned(bus.st_size, bus.st_addr[1:0]);
  assign bus.st_exc = bus.st_valid & mis;
  // Full blocks acceptance even when the head drains this same cycle.
  assign push       = bus.st_valid & !full & !mis & (bus.st_size != st_none);
  assign pop        = !empty & bus.mem_ack;

  always_comb begin
    new_entry.addr = bus.st_addr[31:2];
    new_entry.data = bus.st_data;
    new_entry.be   = be_none;
    case (bus.st_size)
      st_byte: begin
        new_entry.be   = 4'b0001 << bus.st_addr[1:0];
        new_entry.data = {4{bus.st_data[7:0]}};
      end
      st_half: begin
        new_entry.be   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        new_entry.data = {2{bus.st_data[15:0]}};
      end
      st_word: new_entry.be = be_word;
      default: ;
    endcase
  end

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (new_entry),
    .pop         (pop),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .entry_addr  (entry_addr),
    .entry_valid (entry_valid)
  );

  assign bus.st_ready  = !full;
  assign bus.buf_empty = empty;
  assign bus.occupancy = count;
  assign bus.mem_req   = !empty;
  assign bus.mem_addr  = {head.addr, 2'b00};
  assign bus.mem_wdata = head.data;
  assign bus.mem_be    = head.be;

  // Word match only: byte enables are ignored, a partial overlap still stalls.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = entry_valid[i] & (entry_addr[i] == bus.ld_addr[31:2]);
  end

  assign bus.ld_hit    = |match;
  assign unused_ld_low = ^bus.ld_addr[1:0];

endmodule
